// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU. Holds the 8-entry register
// file, sequences each instruction through READ/EXEC/WB, and keeps the
// architectural status flags.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an instruction word
// IMM   | waiting for the immediate word (B operand)
// READ  | read operands from the register file into the ALU inputs
// EXEC  | ALU enabled, result and flags captured at the edge
// WB    | done pulse, write back register and/or status flags
module alu_issue_ctrl #(
   parameter int NREGS = 8,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DW-1:0]            instr,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   output logic [DW-1:0]            alu_A,
   output logic [DW-1:0]            alu_B,
   output logic                     alu_enable,
   output logic [5:0]               alu_opcode,
   input  logic [DW-1:0]            alu_result,
   input  logic [3:0]               alu_flags,
   output logic [3:0]               status_flags,
   output logic                     done,
   output logic                     illegal,
   input  logic [$clog2(NREGS)-1:0] dbg_addr,
   output logic [DW-1:0]            dbg_data
);

   localparam int AW = $clog2(NREGS);

   // ALU opcode encodings shared with the ALU
   localparam logic [5:0] ALU_NOP = 6'd0;
   localparam logic [5:0] ALU_ADD = 6'd1;
   localparam logic [5:0] ALU_SUB = 6'd2;
   localparam logic [5:0] ALU_LSR = 6'd3;
   localparam logic [5:0] ALU_LSL = 6'd4;
   localparam logic [5:0] ALU_RSR = 6'd5;
   localparam logic [5:0] ALU_RSL = 6'd6;
   localparam logic [5:0] ALU_MUL = 6'd7;
   localparam logic [5:0] ALU_DIV = 6'd8;
   localparam logic [5:0] ALU_MOD = 6'd9;
   localparam logic [5:0] ALU_AND = 6'd10;
   localparam logic [5:0] ALU_OR  = 6'd11;
   localparam logic [5:0] ALU_XOR = 6'd12;
   localparam logic [5:0] ALU_NOT = 6'd13;
   localparam logic [5:0] ALU_INC = 6'd14;
   localparam logic [5:0] ALU_DEC = 6'd15;
   localparam logic [5:0] ALU_CMP = 6'd16;
   localparam logic [5:0] ALU_TST = 6'd17;

   typedef enum logic [2:0] {
      S_IDLE,
      S_IMM,
      S_READ,
      S_EXEC,
      S_WB
   } state_t;

   state_t          state;
   logic [DW-1:0]   regs [NREGS];
   logic [5:0]      opcode_q;
   logic [AW-1:0]   rd_q;
   logic [AW-1:0]   rs_q;
   logic            imm_q;
   logic [DW-1:0]   imm_word_q;
   logic [DW-1:0]   result_q;
   logic [3:0]      flags_q;

   function automatic logic op_writes_reg(input logic [5:0] op);
      case (op)
         ALU_ADD, ALU_SUB, ALU_LSR, ALU_LSL, ALU_RSR, ALU_RSL, ALU_MUL,
         ALU_DIV, ALU_MOD, ALU_AND, ALU_OR,  ALU_XOR, ALU_NOT, ALU_INC,
         ALU_DEC: op_writes_reg = 1'b1;
         default: op_writes_reg = 1'b0;
      endcase
   endfunction

   // Everything that writes a register also updates flags, plus CMP/TST
   function automatic logic op_writes_flags(input logic [5:0] op);
      op_writes_flags = op_writes_reg(op) || (op == ALU_CMP) || (op == ALU_TST);
   endfunction

   function automatic logic op_defined(input logic [5:0] op);
      op_defined = op_writes_flags(op) || (op == ALU_NOP);
   endfunction

   assign instr_ready = (state == S_IDLE) || (state == S_IMM);
   assign dbg_data    = regs[dbg_addr];

   // Issue sequencer, register file and status flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         status_flags <= '0;
         alu_A        <= '0;
         alu_B        <= '0;
         alu_opcode   <= '0;
         alu_enable   <= 1'b0;
         done         <= 1'b0;
         illegal      <= 1'b0;
         opcode_q     <= '0;
         rd_q         <= '0;
         rs_q         <= '0;
         imm_q        <= 1'b0;
         imm_word_q   <= '0;
         result_q     <= '0;
         flags_q      <= '0;
      end else begin
         done       <= 1'b0;
         illegal    <= 1'b0;
         alu_enable <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  opcode_q <= instr[15:10];
                  rd_q     <= instr[9:7];
                  rs_q     <= instr[6:4];
                  imm_q    <= instr[3];
                  state    <= instr[3] ? S_IMM : S_READ;
               end
            end
            S_IMM: begin
               if (instr_valid) begin
                  imm_word_q <= instr;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               // operands go straight into the registered ALU inputs
               alu_A      <= regs[rd_q];
               alu_B      <= imm_q ? imm_word_q : regs[rs_q];
               alu_opcode <= opcode_q;
               alu_enable <= 1'b1;
               state      <= S_EXEC;
            end
            S_EXEC: begin
               result_q <= alu_result;
               flags_q  <= alu_flags;
               done     <= 1'b1;
               illegal  <= !op_defined(opcode_q);
               state    <= S_WB;
            end
            S_WB: begin
               if (op_writes_reg(opcode_q))   regs[rd_q]   <= result_q;
               if (op_writes_flags(opcode_q)) status_flags <= flags_q;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the ALU ports, a table of
// instructions with hand-derived expectations fed through a scoreboard, and
// hand-written backpressure and reset-during-EXEC sequences.
module tb_alu_issue_ctrl;

   localparam logic [5:0] OP_NOP = 6'd0;
   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;
   localparam logic [5:0] OP_LSR = 6'd3;
   localparam logic [5:0] OP_LSL = 6'd4;
   localparam logic [5:0] OP_MUL = 6'd7;
   localparam logic [5:0] OP_AND = 6'd10;
   localparam logic [5:0] OP_OR  = 6'd11;
   localparam logic [5:0] OP_XOR = 6'd12;
   localparam logic [5:0] OP_NOT = 6'd13;
   localparam logic [5:0] OP_INC = 6'd14;
   localparam logic [5:0] OP_DEC = 6'd15;
   localparam logic [5:0] OP_CMP = 6'd16;
   localparam logic [5:0] OP_TST = 6'd17;
   localparam logic [5:0] OP_BAD = 6'h3F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] alu_A, alu_B;
   logic        alu_enable;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_result;
   logic [3:0]  alu_flags;
   logic [3:0]  status_flags;
   logic        done, illegal;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_A(alu_A), .alu_B(alu_B),
      .alu_enable(alu_enable), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .status_flags(status_flags), .done(done), .illegal(illegal),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Behavioural ALU: flags = {zero, negative, carry/borrow, 0}
   logic [16:0] alu_wide;
   always_comb begin
      alu_wide = '0;
      case (alu_opcode)
         OP_ADD:         alu_wide = {1'b0, alu_A} + {1'b0, alu_B};
         OP_SUB, OP_CMP: alu_wide = {1'b0, alu_A} - {1'b0, alu_B};
         OP_INC:         alu_wide = {1'b0, alu_A} + 17'd1;
         OP_DEC:         alu_wide = {1'b0, alu_A} - 17'd1;
         OP_AND, OP_TST: alu_wide = {1'b0, alu_A & alu_B};
         OP_OR:          alu_wide = {1'b0, alu_A | alu_B};
         OP_XOR:         alu_wide = {1'b0, alu_A ^ alu_B};
         OP_NOT:         alu_wide = {1'b0, ~alu_A};
         OP_LSL:         alu_wide = {1'b0, alu_A << 1};
         OP_LSR:         alu_wide = {1'b0, alu_A >> 1};
         OP_MUL:         alu_wide = {1'b0, alu_A * alu_B};
         default:        alu_wide = '0;
      endcase
   end
   assign alu_result = alu_wide[15:0];
   assign alu_flags  = {alu_wide[15:0] == 16'd0, alu_wide[15], alu_wide[16], 1'b0};

   typedef struct {
      logic [15:0] w;
      logic [15:0] iw;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [5:0]  op;
      logic        ill;
      logic [3:0]  flags;
      logic [15:0] rdval;
      int          acc;
      int          lat;
   } vec_t;

   int nchk = 0;
   int nerr = 0;
   int ndone = 0;
   vec_t sbq[$];
   vec_t cur;
   logic chk_pend = 1'b0;
   logic seen_exec = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mkv(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                input logic imm, input logic [15:0] iw,
                                input logic [15:0] a, input logic [15:0] b, input logic ill,
                                input logic [3:0] flags, input logic [15:0] rdval);
      vec_t v;
      v.w = {op, rd, rs, imm, 3'b000};
      v.iw = iw; v.rd = rd; v.a = a; v.b = b; v.op = op; v.ill = ill;
      v.flags = flags; v.rdval = rdval; v.acc = 0; v.lat = imm ? 4 : 3;
      return v;
   endfunction

   // Scoreboard monitor: EXEC operands, done/illegal/latency, then flags and
   // destination register one cycle after done
   always @(negedge clk) begin
      if (!rst) begin
         if (chk_pend) begin
            chk("status_flags", {28'd0, status_flags}, {28'd0, cur.flags});
            chk("rd_value", {16'd0, dbg_data}, {16'd0, cur.rdval});
            chk_pend = 1'b0;
         end
         if (alu_enable && sbq.size() != 0) begin
            chk("exec_A", {16'd0, alu_A}, {16'd0, sbq[0].a});
            chk("exec_B", {16'd0, alu_B}, {16'd0, sbq[0].b});
            chk("exec_op", {26'd0, alu_opcode}, {26'd0, sbq[0].op});
            seen_exec = 1'b1;
         end
         if (done) begin
            ndone++;
            if (sbq.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               cur = sbq.pop_front();
               chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
               chk("done_latency", cyc, cur.acc + cur.lat);
               chk("exec_seen", {31'd0, seen_exec}, 32'd1);
               seen_exec = 1'b0;
               dbg_addr = cur.rd;
               chk_pend = 1'b1;
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
   endtask

   // Called at a negedge; returns at the negedge after the last word is taken
   task automatic issue(input vec_t v, output int acc);
      instr = v.w;
      instr_valid = 1'b1;
      wait_ready();
      v.acc = cyc;
      acc = cyc;
      sbq.push_back(v);
      @(negedge clk);
      if (v.w[3]) begin
         instr = v.iw;
         wait_ready();
         @(negedge clk);
      end
      instr_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || chk_pend) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sbq.size(), 0);
   endtask

   vec_t tbl[12];

   initial begin
      int acc1, acc2, dummy;
      tbl[0]  = mkv(OP_ADD, 3'd1, 3'd0, 1'b1, 16'd10,   16'd0,    16'd10,   1'b0, 4'b0000, 16'd10);
      tbl[1]  = mkv(OP_ADD, 3'd2, 3'd0, 1'b1, 16'd1,    16'd0,    16'd1,    1'b0, 4'b0000, 16'd1);
      tbl[2]  = mkv(OP_SUB, 3'd1, 3'd2, 1'b0, 16'd0,    16'd10,   16'd1,    1'b0, 4'b0000, 16'd9);
      tbl[3]  = mkv(OP_CMP, 3'd1, 3'd2, 1'b0, 16'd0,    16'd9,    16'd1,    1'b0, 4'b0000, 16'd9);
      tbl[4]  = mkv(OP_CMP, 3'd2, 3'd1, 1'b0, 16'd0,    16'd1,    16'd9,    1'b0, 4'b0110, 16'd1);
      tbl[5]  = mkv(OP_NOP, 3'd0, 3'd0, 1'b0, 16'd0,    16'd0,    16'd0,    1'b0, 4'b0110, 16'd0);
      tbl[6]  = mkv(OP_BAD, 3'd1, 3'd2, 1'b0, 16'd0,    16'd9,    16'd1,    1'b1, 4'b0110, 16'd9);
      tbl[7]  = mkv(OP_AND, 3'd3, 3'd0, 1'b1, 16'h00F0, 16'd0,    16'h00F0, 1'b0, 4'b1000, 16'd0);
      tbl[8]  = mkv(OP_XOR, 3'd3, 3'd0, 1'b1, 16'hFFFF, 16'd0,    16'hFFFF, 1'b0, 4'b0100, 16'hFFFF);
      tbl[9]  = mkv(OP_INC, 3'd3, 3'd0, 1'b0, 16'd0,    16'hFFFF, 16'd0,    1'b0, 4'b1010, 16'd0);
      tbl[10] = mkv(OP_ADD, 3'd2, 3'd2, 1'b0, 16'd0,    16'd1,    16'd1,    1'b0, 4'b0000, 16'd2);
      tbl[11] = mkv(OP_SUB, 3'd4, 3'd2, 1'b0, 16'd0,    16'd0,    16'd2,    1'b0, 4'b0110, 16'hFFFE);

      // reset for two cycles, then check idle state and a cleared register file
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_enable", {31'd0, alu_enable}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_flags", {28'd0, status_flags}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("rst_reg", {16'd0, dbg_data}, 32'd0);
      end
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         issue(tbl[i], dummy);
         drain();
      end

      // valid held high with a new instruction across a whole operation
      issue(mkv(OP_INC, 3'd5, 3'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 4'b0000, 16'd1), acc1);
      issue(mkv(OP_INC, 3'd5, 3'd0, 1'b0, 16'd0, 16'd1, 16'd0, 1'b0, 4'b0000, 16'd2), acc2);
      chk("backpressure_accept", acc2 - acc1, 4);
      drain();
      repeat (4) @(negedge clk);
      chk("backpressure_count", ndone, 14);

      // reset asserted while INC r1 is in EXEC
      instr = {OP_INC, 3'd1, 3'd0, 1'b0, 3'b000};
      instr_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("midrst_exec", {31'd0, alu_enable}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
      chk("midrst_enable", {31'd0, alu_enable}, 32'd0);
      chk("midrst_alu_A", {16'd0, alu_A}, 32'd0);
      dbg_addr = 3'd1;
      #1;
      chk("midrst_r1", {16'd0, dbg_data}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst_no_done", ndone, 14);
      chk("midrst_idle", {31'd0, instr_ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
